sound_event_scheduler: RTL and testbench

//  Arbitrates game sound requests (paddle, wall, brick, game-over) for the single tone generator.

---
 rtl/sound_event_scheduler_if.sv | 19 +
 rtl/sound_event_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_sound_event_scheduler.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sound_event_scheduler_if.sv
// Request/status bundle between game logic (master) and the sound event scheduler (slave).
interface sound_event_scheduler_if;
  logic [3:0] req_i;
  logic [2:0] note_sel;
  logic       sound_active;
  logic       busy;
  logic [3:0] grant;
  logic       done;

  modport master (
    output req_i,
    input  note_sel, sound_active, busy, grant, done
  );

  modport slave (
    input  req_i,
    output note_sel, sound_active, busy, grant, done
  );
endinterface

// File: rtl/sound_event_scheduler.sv
// Fixed-priority arbiter that plays one game sound sequence at a time on the tone generator.
// Optional macro SND_PREEMPT_EN lets a higher-priority request abort the sequence in progress.
module sound_event_scheduler #(
  parameter int unsigned NOTE_TICKS = 2500000,
  parameter int unsigned GAP_TICKS  = 250000
) (
  input  logic                    clk50mhz,
  input  logic                    reset_button,
  sound_event_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;

  localparam logic [31:0] NOTE_LAST = 32'(NOTE_TICKS - 1);
  localparam logic [31:0] GAP_LAST  = (GAP_TICKS == 0) ? 32'd0 : 32'(GAP_TICKS - 1);
  localparam bit          HAS_GAP   = (GAP_TICKS != 0);

  function automatic logic [3:0] pick_highest(input logic [3:0] v);
    logic [3:0] g;
    g = 4'b0000;
    if (v[3])      g = 4'b1000;
    else if (v[2]) g = 4'b0100;
    else if (v[1]) g = 4'b0010;
    else if (v[0]) g = 4'b0001;
    return g;
  endfunction

  function automatic logic [1:0] last_index(input logic [3:0] g);
    logic [1:0] l;
    case (g)
      4'b1000: l = 2'd3;
      4'b0100: l = 2'd1;
      default: l = 2'd0;
    endcase
    return l;
  endfunction

  // Sequence ROM: 001 do, 010 re, 011 mi, 100 sol.
  function automatic logic [2:0] seq_note(input logic [3:0] g, input logic [1:0] idx);
    logic [2:0] n;
    n = 3'b000;
    case (g)
      4'b0001: n = 3'b001;
      4'b0010: n = 3'b010;
      4'b0100: n = (idx == 2'd0) ? 3'b011 : 3'b100;
      4'b1000: begin
        case (idx)
          2'd0:    n = 3'b100;
          2'd1:    n = 3'b011;
          2'd2:    n = 3'b010;
          default: n = 3'b001;
        endcase
      end
      default: n = 3'b000;
    endcase
    return n;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  grant_q, grant_d;
  logic [2:0]  note_q, note_d;
  logic        done_q, done_d;
  logic [3:0]  pending_q, pending_d;

  logic [3:0]  req_all;
  logic [3:0]  next_grant;
  logic        preempt;
  logic        start;
  logic        advance;

  assign req_all    = pending_q | bus.req_i;
  assign next_grant = pick_highest(req_all);

`ifdef SND_PREEMPT_EN
  logic [3:0] higher_mask;
  assign higher_mask = {|grant_q[2:0], |grant_q[1:0], grant_q[0], 1'b0};
  assign preempt     = |(req_all & higher_mask);
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    grant_d   = grant_q;
    note_d    = note_q;
    done_d    = 1'b0;
    pending_d = req_all;
    start     = 1'b0;
    advance   = 1'b0;

    case (state_q)
      IDLE: start = |req_all;
      PLAY: begin
        if (preempt) begin
          done_d = 1'b1;
          start  = 1'b1;
        end else if (cnt_q == NOTE_LAST) begin
          if (HAS_GAP) begin
            state_d = GAP;
            note_d  = 3'b000;
            cnt_d   = 32'd0;
          end else begin
            advance = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      GAP: begin
        if (preempt) begin
          done_d = 1'b1;
          start  = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (idx_q != last_index(grant_q)) begin
        idx_d   = idx_q + 2'd1;
        note_d  = seq_note(grant_q, idx_q + 2'd1);
        state_d = PLAY;
        cnt_d   = 32'd0;
      end else begin
        done_d = 1'b1;
        if (|req_all) begin
          start = 1'b1;
        end else begin
          state_d = IDLE;
          grant_d = 4'b0000;
          note_d  = 3'b000;
          idx_d   = 2'd0;
          cnt_d   = 32'd0;
        end
      end
    end

    // Clearing from req_all absorbs a same-cycle pulse on the bit being granted.
    if (start) begin
      grant_d   = next_grant;
      idx_d     = 2'd0;
      note_d    = seq_note(next_grant, 2'd0);
      state_d   = PLAY;
      cnt_d     = 32'd0;
      pending_d = req_all & ~next_grant;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk50mhz) begin
    if (reset_button) begin
      state_q   <= IDLE;
      cnt_q     <= 32'd0;
      idx_q     <= 2'd0;
      grant_q   <= 4'b0000;
      note_q    <= 3'b000;
      done_q    <= 1'b0;
      pending_q <= 4'b0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      grant_q   <= grant_d;
      note_q    <= note_d;
      done_q    <= done_d;
      pending_q <= pending_d;
    end
  end

  assign bus.note_sel     = note_q;
  assign bus.sound_active = (note_q != 3'b000);
  assign bus.busy         = (state_q != IDLE);
  assign bus.grant        = grant_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_sound_event_scheduler.sv
// Directed bench for sound_event_scheduler with NOTE_TICKS=4, GAP_TICKS=2; outputs sampled 1 time unit after each rising edge.
module tb_sound_event_scheduler;
  localparam int NT = 4;
  localparam int GT = 2;

  logic clk50mhz = 1'b0;
  logic reset_button;
  int   checks = 0;
  int   errors = 0;

  sound_event_scheduler_if bus ();

  sound_event_scheduler #(.NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
    .clk50mhz     (clk50mhz),
    .reset_button (reset_button),
    .bus          (bus)
  );

  always #10 clk50mhz = ~clk50mhz;

  task automatic step();
    @(posedge clk50mhz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [2:0] note, input logic [3:0] grant,
                              input logic busy, input logic done);
    check({tag, ".note_sel"},     32'(bus.note_sel),     32'(note));
    check({tag, ".sound_active"}, 32'(bus.sound_active), 32'(note != 3'b000));
    check({tag, ".grant"},        32'(bus.grant),        32'(grant));
    check({tag, ".busy"},         32'(bus.busy),         32'(busy));
    check({tag, ".done"},         32'(bus.done),         32'(done));
  endtask

  // Checks the remaining cycles of a note starting at cycle index 'from'.
  task automatic note_cycles(input string tag, input logic [2:0] note, input logic [3:0] grant,
                             input logic first_done, input int from);
    for (int i = from; i < NT; i++) begin
      expect_state(tag, note, grant, 1'b1, (i == 0) ? first_done : 1'b0);
      step();
    end
  endtask

  task automatic gap_cycles(input string tag, input logic [3:0] grant, input int n);
    for (int i = 0; i < n; i++) begin
      expect_state(tag, 3'b000, grant, 1'b1, 1'b0);
      step();
    end
  endtask

  task automatic pulse(input logic [3:0] v);
    bus.req_i = v;
    step();
    bus.req_i = 4'b0000;
  endtask

  initial begin
    // Reset with requests held: they must be ignored.
    reset_button = 1'b1;
    bus.req_i    = 4'b1111;
    step();
    step();
    reset_button = 1'b0;
    bus.req_i    = 4'b0000;
    expect_state("reset", 3'b000, 4'b0000, 1'b0, 1'b0);
    step();
    expect_state("post_reset_idle", 3'b000, 4'b0000, 1'b0, 1'b0);

    // 1: single paddle request.
    pulse(4'b0001);
    note_cycles("t1_do", 3'b001, 4'b0001, 1'b0, 0);
    gap_cycles("t1_gap", 4'b0001, GT);
    expect_state("t1_done", 3'b000, 4'b0000, 1'b0, 1'b1);
    step();
    expect_state("t1_idle", 3'b000, 4'b0000, 1'b0, 1'b0);

    // 2: all four at once, served back-to-back by priority.
    pulse(4'b1111);
    note_cycles("t2_r3_sol", 3'b100, 4'b1000, 1'b0, 0);
    gap_cycles("t2_r3_g0", 4'b1000, GT);
    note_cycles("t2_r3_mi", 3'b011, 4'b1000, 1'b0, 0);
    gap_cycles("t2_r3_g1", 4'b1000, GT);
    note_cycles("t2_r3_re", 3'b010, 4'b1000, 1'b0, 0);
    gap_cycles("t2_r3_g2", 4'b1000, GT);
    note_cycles("t2_r3_do", 3'b001, 4'b1000, 1'b0, 0);
    gap_cycles("t2_r3_g3", 4'b1000, GT);
    note_cycles("t2_r2_mi", 3'b011, 4'b0100, 1'b1, 0);
    gap_cycles("t2_r2_g0", 4'b0100, GT);
    note_cycles("t2_r2_sol", 3'b100, 4'b0100, 1'b0, 0);
    gap_cycles("t2_r2_g1", 4'b0100, GT);
    note_cycles("t2_r1_re", 3'b010, 4'b0010, 1'b1, 0);
    gap_cycles("t2_r1_g0", 4'b0010, GT);
    note_cycles("t2_r0_do", 3'b001, 4'b0001, 1'b1, 0);
    gap_cycles("t2_r0_g0", 4'b0001, GT);
    expect_state("t2_done", 3'b000, 4'b0000, 1'b0, 1'b1);
    step();
    expect_state("t2_idle", 3'b000, 4'b0000, 1'b0, 1'b0);

    // 3a: brick re-requested mid-note replays once afterwards.
    pulse(4'b0100);
    expect_state("t3a_mi_c0", 3'b011, 4'b0100, 1'b1, 1'b0);
    pulse(4'b0100);
    note_cycles("t3a_mi", 3'b011, 4'b0100, 1'b0, 1);
    gap_cycles("t3a_g0", 4'b0100, GT);
    note_cycles("t3a_sol", 3'b100, 4'b0100, 1'b0, 0);
    gap_cycles("t3a_g1", 4'b0100, GT);
    note_cycles("t3a_re_mi", 3'b011, 4'b0100, 1'b1, 0);
    gap_cycles("t3a_g2", 4'b0100, GT);
    note_cycles("t3a_re_sol", 3'b100, 4'b0100, 1'b0, 0);
    gap_cycles("t3a_g3", 4'b0100, GT);
    expect_state("t3a_done", 3'b000, 4'b0000, 1'b0, 1'b1);
    step();
    expect_state("t3a_idle", 3'b000, 4'b0000, 1'b0, 1'b0);

    // 3b: brick queued, then pulsed again in its own grant cycle: plays once.
    pulse(4'b0001);
    expect_state("t3b_do_c0", 3'b001, 4'b0001, 1'b1, 1'b0);
    pulse(4'b0100);
    note_cycles("t3b_do", 3'b001, 4'b0001, 1'b0, 1);
    gap_cycles("t3b_g0", 4'b0001, GT - 1);
    expect_state("t3b_glast", 3'b000, 4'b0001, 1'b1, 1'b0);
    pulse(4'b0100);
    note_cycles("t3b_mi", 3'b011, 4'b0100, 1'b1, 0);
    gap_cycles("t3b_g1", 4'b0100, GT);
    note_cycles("t3b_sol", 3'b100, 4'b0100, 1'b0, 0);
    gap_cycles("t3b_g2", 4'b0100, GT);
    expect_state("t3b_done", 3'b000, 4'b0000, 1'b0, 1'b1);
    step();
    expect_state("t3b_idle0", 3'b000, 4'b0000, 1'b0, 1'b0);
    step();
    expect_state("t3b_idle1", 3'b000, 4'b0000, 1'b0, 1'b0);

    // 4: reset during the 2nd note of game-over, with wall queued.
    pulse(4'b1000);
    expect_state("t4_sol_c0", 3'b100, 4'b1000, 1'b1, 1'b0);
    pulse(4'b0010);
    note_cycles("t4_sol", 3'b100, 4'b1000, 1'b0, 1);
    gap_cycles("t4_g0", 4'b1000, GT);
    expect_state("t4_mi_c0", 3'b011, 4'b1000, 1'b1, 1'b0);
    step();
    reset_button = 1'b1;
    bus.req_i    = 4'b0001;
    step();
    expect_state("t4_in_reset", 3'b000, 4'b0000, 1'b0, 1'b0);
    reset_button = 1'b0;
    bus.req_i    = 4'b0000;
    step();
    expect_state("t4_after0", 3'b000, 4'b0000, 1'b0, 1'b0);
    step();
    expect_state("t4_after1", 3'b000, 4'b0000, 1'b0, 1'b0);

    // 5: game-over arrives during cycle 2 of the paddle note.
    pulse(4'b0001);
    expect_state("t5_do_c0", 3'b001, 4'b0001, 1'b1, 1'b0);
    step();
    expect_state("t5_do_c1", 3'b001, 4'b0001, 1'b1, 1'b0);
    pulse(4'b1000);
`ifdef SND_PREEMPT_EN
    note_cycles("t5_sol", 3'b100, 4'b1000, 1'b1, 0);
`else
    note_cycles("t5_do", 3'b001, 4'b0001, 1'b0, 2);
    gap_cycles("t5_do_gap", 4'b0001, GT);
    note_cycles("t5_sol", 3'b100, 4'b1000, 1'b1, 0);
`endif
    gap_cycles("t5_g0", 4'b1000, GT);
    note_cycles("t5_mi", 3'b011, 4'b1000, 1'b0, 0);
    gap_cycles("t5_g1", 4'b1000, GT);
    note_cycles("t5_re", 3'b010, 4'b1000, 1'b0, 0);
    gap_cycles("t5_g2", 4'b1000, GT);
    note_cycles("t5_do_end", 3'b001, 4'b1000, 1'b0, 0);
    gap_cycles("t5_g3", 4'b1000, GT);
    expect_state("t5_done", 3'b000, 4'b0000, 1'b0, 1'b1);
    step();
    expect_state("t5_idle0", 3'b000, 4'b0000, 1'b0, 1'b0);
    step();
    expect_state("t5_idle1", 3'b000, 4'b0000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
